// File: rtl/master_port_pkg.sv
// Shared bus definitions: FSM encoding, slave-select code layout and
// the start marker that leads every code.
package master_port_pkg;

  typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, DONE} state_e;

  localparam int   SS_CODE_W    = 3;
  localparam logic START_MARKER = 1'b1;

  function automatic logic [SS_CODE_W-1:0] ss_code(input logic [1:0] slave);
    return {slave, START_MARKER};
  endfunction

endpackage

// File: rtl/serial_shifter.sv
// PISO/SIPO bit engine shared by the address and data phases. Exposes the
// bit that follows the next shift, so the caller can register it directly.
module serial_shifter
  import master_port_pkg::*;
#(
  parameter int SW = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [SW-1:0] load_data,
  input  logic [CW-1:0] load_len,
  input  logic          step,
  input  logic          sample,
  input  logic          din,
  output logic          nxt,
  output logic          last,
  output logic [SW-1:0] rx_nxt
);
  logic [SW-1:0] sh, rx;
  logic [CW-1:0] idx, len;

  assign nxt  = sh[1];
  assign last = (idx == len - 1'b1);

  // Received bits land at their own index, so an aborted word keeps
  // the bits received so far and zeros above them.
  always_comb begin
    rx_nxt = rx;
    for (int i = 0; i < SW; i++)
      if (sample && idx == CW'(i)) rx_nxt[i] = din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh  <= '0;
      rx  <= '0;
      idx <= '0;
      len <= '0;
    end else if (load) begin
      sh  <= load_data;
      rx  <= '0;
      idx <= '0;
      len <= load_len;
    end else if (step) begin
      sh  <= sh >> 1;
      rx  <= rx_nxt;
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/master_port.sv
// Serial bus master port: request/grant handshake, serial slave-select
// code, then one serial data word written or read LSB first.
module master_port
  import master_port_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int GRANT_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [1:0]            cmd_slave,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  request,
  input  logic                  grant,
  output logic                  slave_select,
  output logic                  bus_dir,
  output logic                  bus_dout,
  input  logic                  bus_din,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);
  localparam int SW = (DATA_WIDTH > SS_CODE_W) ? DATA_WIDTH : SS_CODE_W;
  localparam int CW = $clog2(SW + 1);
  localparam int TW = $clog2(GRANT_TIMEOUT + 1);

  state_e                state;
  logic                  wr;
  logic [1:0]            slv;
  logic [DATA_WIDTH-1:0] wdata;
  logic [TW-1:0]         wait_cnt;

  logic          ld, step, sample, nxt, last, fin, fin_err;
  logic [SW-1:0] ld_data, rx_nxt;
  logic [CW-1:0] ld_len;

  assign cmd_ready = (state == IDLE);

  always_comb begin
    ld      = 1'b0;
    ld_data = '0;
    ld_len  = '0;
    step    = 1'b0;
    sample  = 1'b0;
    fin     = 1'b0;
    fin_err = 1'b0;
    case (state)
      REQ: begin
        if (grant) begin
          ld      = 1'b1;
          ld_data = SW'(ss_code(slv));
          ld_len  = CW'(SS_CODE_W);
        end else if (wait_cnt == TW'(GRANT_TIMEOUT - 1)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      ADDR: begin
        if (!grant) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (last) begin
          ld      = 1'b1;
          ld_data = SW'(wdata);
          ld_len  = CW'(DATA_WIDTH);
        end else begin
          step = 1'b1;
        end
      end
      DATA: begin
        if (!grant) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          step   = 1'b1;
          sample = !wr;
          fin    = last;
        end
      end
      default: ;
    endcase
  end

  serial_shifter #(.SW(SW), .CW(CW)) u_shf (
    .clk       (clk),
    .reset     (reset),
    .load      (ld),
    .load_data (ld_data),
    .load_len  (ld_len),
    .step      (step),
    .sample    (sample),
    .din       (bus_din),
    .nxt       (nxt),
    .last      (last),
    .rx_nxt    (rx_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wr           <= 1'b0;
      slv          <= '0;
      wdata        <= '0;
      wait_cnt     <= '0;
      request      <= 1'b0;
      slave_select <= 1'b0;
      bus_dir      <= 1'b0;
      bus_dout     <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else if (fin) begin
      state        <= DONE;
      wait_cnt     <= '0;
      request      <= 1'b0;
      slave_select <= 1'b0;
      bus_dir      <= 1'b0;
      bus_dout     <= 1'b0;
      rsp_valid    <= 1'b1;
      rsp_err      <= fin_err;
      // A timeout never received a bit; shifter may hold a stale word.
      rsp_rdata    <= (state == REQ) ? '0 : rx_nxt[DATA_WIDTH-1:0];
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          state    <= REQ;
          request  <= 1'b1;
          wr       <= cmd_write;
          slv      <= cmd_slave;
          wdata    <= cmd_wdata;
          wait_cnt <= '0;
        end
        REQ: begin
          if (grant) begin
            state        <= ADDR;
            wait_cnt     <= '0;
            slave_select <= START_MARKER;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ADDR: begin
          if (last) begin
            state        <= DATA;
            slave_select <= 1'b0;
            bus_dir      <= wr;
            bus_dout     <= wr & wdata[0];
          end else begin
            slave_select <= nxt;
          end
        end
        DATA:    bus_dout <= wr & nxt;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
